// File: rtl/pipeline_controller_pkg.sv
// Shared types and defaults for the pipeline run-control / hazard sequencer.
package proc_ctrl_pkg;

    // Run-control states of the controller FSM
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

    // Cycles after a halt leaves ID before the pipe is empty (EX, MEM, WB)
    localparam int DRAIN_CYC_DEF = 3;

endpackage

// File: rtl/pipeline_controller_if.sv
// Bundle of run-control, hazard-detect inputs and pipeline-control outputs
// shared between the datapath side (master) and the controller (slave).
interface pipeline_controller_if #(
    parameter int RA_W  = 4,
    parameter int CNT_W = 32
);
    logic              start;
    logic              halt_id;
    logic              use_ra1_id;
    logic              use_ra2_id;
    logic [RA_W-1:0]   RA1_id;
    logic [RA_W-1:0]   RA2_id;
    logic              MemRead_ex;
    logic [RA_W-1:0]   RA3_ex;
    logic              PCSource_ex;

    logic              pc_en;
    logic              pc_clear;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              running;
    logic              done;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // Datapath side: drives pipeline status, receives control
    modport master (
        output start, halt_id, use_ra1_id, use_ra2_id, RA1_id, RA2_id,
               MemRead_ex, RA3_ex, PCSource_ex,
        input  pc_en, pc_clear, if_id_en, if_id_flush, id_ex_flush,
               running, done, cycle_cnt, stall_cnt, flush_cnt
    );

    // Controller side
    modport slave (
        input  start, halt_id, use_ra1_id, use_ra2_id, RA1_id, RA2_id,
               MemRead_ex, RA3_ex, PCSource_ex,
        output pc_en, pc_clear, if_id_en, if_id_flush, id_ex_flush,
               running, done, cycle_cnt, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_controller_hazard_unit.sv
// Load-use hazard detector: a load in EX whose destination matches a
// source register actually read by the instruction in ID.
module hazard_unit #(
    parameter int RA_W = 4
) (
    input  logic            MemRead_ex,
    input  logic            use_ra1_id,
    input  logic            use_ra2_id,
    input  logic [RA_W-1:0] RA1_id,
    input  logic [RA_W-1:0] RA2_id,
    input  logic [RA_W-1:0] RA3_ex,
    output logic            hazard
);

    // Pure compare; the controller decides what to do with it
    always_comb begin
        hazard = MemRead_ex &
                 ((use_ra1_id & (RA1_id == RA3_ex)) |
                  (use_ra2_id & (RA2_id == RA3_ex)));
    end

endmodule

// File: rtl/pipeline_controller.sv
// Run-control and hazard sequencer for the 5-stage datapath. Pipeline
// controls are decoded combinationally from state and current inputs;
// state, drain counter and performance counters are registered.
module pipeline_controller
    import proc_ctrl_pkg::*;
#(
    parameter int RA_W      = 4,
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input logic                clk,
    input logic                rst,
    pipeline_controller_if.slave bus
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    ctrl_state_t      state;
    logic [DW-1:0]    drain_ctr;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic hazard;
    logic take_branch;
    logic take_stall;
    logic take_halt;

    logic pc_en;
    logic pc_clear;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic running;
    logic done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    hazard_unit #(.RA_W(RA_W)) u_hazard (
        .MemRead_ex (bus.MemRead_ex),
        .use_ra1_id (bus.use_ra1_id),
        .use_ra2_id (bus.use_ra2_id),
        .RA1_id     (bus.RA1_id),
        .RA2_id     (bus.RA2_id),
        .RA3_ex     (bus.RA3_ex),
        .hazard     (hazard)
    );

    // Decode pipeline controls; reset forces the idle (bubble-everything) pattern
    always_comb begin
        pc_en       = 1'b0;
        pc_clear    = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        running     = 1'b0;
        done        = 1'b0;
        take_branch = 1'b0;
        take_stall  = 1'b0;
        take_halt   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    pc_clear = bus.start;
                end
                DONE: begin
                    done     = 1'b1;
                    pc_clear = bus.start;
                end
                RUN: begin
                    running     = 1'b1;
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b0;
                    id_ex_flush = 1'b0;
                    if (bus.PCSource_ex) begin
                        take_branch = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (hazard) begin
                        take_stall  = 1'b1;
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (bus.halt_id) begin
                        take_halt   = 1'b1;
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                DRAIN: begin
                    running = 1'b1;
                end
                default: begin
                    pc_en = 1'b0;
                end
            endcase
        end
    end

    // FSM, drain countdown and saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drain_ctr <= '0;
            cycle_q   <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        cycle_q <= '0;
                        stall_q <= '0;
                        flush_q <= '0;
                    end
                end
                RUN: begin
                    cycle_q <= sat_inc(cycle_q);
                    if (take_branch) begin
                        flush_q <= sat_inc(flush_q);
                    end else if (take_stall) begin
                        stall_q <= sat_inc(stall_q);
                    end else if (take_halt) begin
                        drain_ctr <= DW'(DRAIN_CYC - 1);
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    cycle_q <= sat_inc(cycle_q);
                    if (drain_ctr == '0) begin
                        state <= DONE;
                    end else begin
                        drain_ctr <= drain_ctr - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Drive the interface outputs
    always_comb begin
        bus.pc_en       = pc_en;
        bus.pc_clear    = pc_clear;
        bus.if_id_en    = if_id_en;
        bus.if_id_flush = if_id_flush;
        bus.id_ex_flush = id_ex_flush;
        bus.running     = running;
        bus.done        = done;
        bus.cycle_cnt   = cycle_q;
        bus.stall_cnt   = stall_q;
        bus.flush_cnt   = flush_q;
    end

endmodule
